// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched 1..PAT_W-bit pattern out MSB-first, repeated back-to-back.
// Define SEQ_TX_PARITY_EN to append an even-parity bit after every repetition.
module seq_pattern_tx #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

`ifdef SEQ_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

  state_t           state_reg;
  logic [PAT_W-1:0] pat_reg;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] idx_reg;
  logic [CNT_W-1:0] reps_reg;

  logic [PAT_W-1:0] pat_mask;
  logic [PAT_W-1:0] first_sh;
  logic [PAT_W-1:0] next_sh;
  logic [PAT_W-1:0] reload_sh;
  logic             len_ok;

  // Bits above pat_len are cleared on load so parity can XOR the whole register.
  for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
    assign pat_mask[gi] = (pat_len > LEN_W'(gi));
  end

  assign len_ok    = (pat_len != '0) && (pat_len <= MAX_LEN);
  assign first_sh  = pattern >> (pat_len - LEN_W'(1));
  assign next_sh   = pat_reg >> (idx_reg - LEN_W'(1));
  assign reload_sh = pat_reg >> (len_reg - LEN_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      pat_reg    <= '0;
      len_reg    <= '0;
      idx_reg    <= '0;
      reps_reg   <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              pat_reg    <= pattern & pat_mask;
              len_reg    <= pat_len;
              idx_reg    <= pat_len - LEN_W'(1);
              reps_reg   <= (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
              dout       <= first_sh[0];
              dout_valid <= 1'b1;
              busy       <= 1'b1;
              state_reg  <= SHIFT;
            end else begin
              err <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (idx_reg != '0) begin
            idx_reg <= idx_reg - LEN_W'(1);
            dout    <= next_sh[0];
`ifdef SEQ_TX_PARITY_EN
          end else begin
            dout      <= ^pat_reg;
            state_reg <= PARITY;
          end
        end
        PARITY: begin
          if (reps_reg != CNT_W'(1)) begin
            reps_reg  <= reps_reg - CNT_W'(1);
            idx_reg   <= len_reg - LEN_W'(1);
            dout      <= reload_sh[0];
            state_reg <= SHIFT;
`else
          end else if (reps_reg != CNT_W'(1)) begin
            // next repetition starts on the very next cycle
            reps_reg <= reps_reg - CNT_W'(1);
            idx_reg  <= len_reg - LEN_W'(1);
            dout     <= reload_sh[0];
`endif
          end else begin
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx; expected streams are hand-computed.
// Expectations for the parity build follow SEQ_TX_PARITY_EN.
module tb_seq_pattern_tx;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] pat_len;
  logic [7:0] repeat_cnt;
  logic       dout, dout_valid, busy, done, err;

  int checks = 0;
  int errors = 0;

  seq_pattern_tx #(.PAT_W(8), .LEN_W(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern),
    .pat_len(pat_len), .repeat_cnt(repeat_cnt), .dout(dout),
    .dout_valid(dout_valid), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive start for one edge; returns at the negedge of cycle 1 with inputs scrambled.
  task automatic send(input logic [7:0] p, input logic [3:0] l, input logic [7:0] r);
    @(negedge clk);
    pattern = p; pat_len = l; repeat_cnt = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0; pattern = ~p; pat_len = 4'd2; repeat_cnt = 8'd7;
  endtask

  task automatic run(input string tag, input logic [7:0] p, input logic [3:0] l,
                     input logic [7:0] r, input logic [31:0] exp, input int n, output int hits);
    logic [3:0] shreg = 4'b0;
    hits = 0;
    send(p, l, r);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      check({tag, "_valid"}, 32'(dout_valid), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_bit"}, 32'(dout), 32'(exp[n-1-i]));
      shreg = {shreg[2:0], dout};
      if (shreg == 4'b1001) hits++;
    end
    @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_done_busy"}, 32'(busy), 32'd0);
    check({tag, "_done_valid"}, 32'(dout_valid), 32'd0);
    check({tag, "_done_dout"}, 32'(dout), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    $display("%s: %0d bits, 1001 hits=%0d", tag, n, hits);
  endtask

  initial begin
    int hits;
    int cnt;
    bit seen;
    reset = 1'b1; start = 1'b0; pattern = '0; pat_len = '0; repeat_cnt = '0;
    repeat (3) @(negedge clk);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    $display("reset: outputs idle");

`ifdef SEQ_TX_PARITY_EN
    run("t1", 8'h09, 4'd4, 8'd1, 32'b10010, 5, hits);
    run("t2", 8'h09, 4'd4, 8'd3, 32'b100101001010010, 15, hits);
`else
    run("t1", 8'h09, 4'd4, 8'd1, 32'b1001, 4, hits);
    run("t2", 8'h09, 4'd4, 8'd3, 32'b100110011001, 12, hits);
`endif
    check("t2_detect", 32'(hits), 32'd3);

    send(8'h09, 4'd0, 8'd1);
    check("t3a_err", 32'(err), 32'd1);
    check("t3a_busy", 32'(busy), 32'd0);
    check("t3a_valid", 32'(dout_valid), 32'd0);
    @(negedge clk);
    check("t3a_err_pulse", 32'(err), 32'd0);
    check("t3a_done", 32'(done), 32'd0);
    send(8'h09, 4'd9, 8'd1);
    check("t3b_err", 32'(err), 32'd1);
    check("t3b_busy", 32'(busy), 32'd0);
    check("t3b_valid", 32'(dout_valid), 32'd0);
    @(negedge clk);
    check("t3b_err_pulse", 32'(err), 32'd0);
    check("t3b_valid2", 32'(dout_valid), 32'd0);
    $display("t3: illegal lengths rejected");

    send(8'h09, 4'd4, 8'd1);
    check("t4_bit1", 32'(dout), 32'd1);
    @(negedge clk);
    check("t4_bit2", 32'(dout), 32'd0);
    pattern = 8'h0F; pat_len = 4'd4; repeat_cnt = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t4_bit3", 32'(dout), 32'd0);
    check("t4_bit3_valid", 32'(dout_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t4_rst_dout", 32'(dout), 32'd0);
    check("t4_rst_valid", 32'(dout_valid), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_done", 32'(done), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("t4_no_done", 32'(done), 32'd0);
      check("t4_no_valid", 32'(dout_valid), 32'd0);
    end
    $display("t4: restart ignored, reset aborted stream");

`ifdef SEQ_TX_PARITY_EN
    run("t5", 8'h0B, 4'd4, 8'd2, 32'b1011110111, 10, hits);
    run("t6", 8'hF6, 4'd3, 8'd0, 32'b1100, 4, hits);
`else
    run("t5", 8'h0B, 4'd4, 8'd2, 32'b10111011, 8, hits);
    run("t6", 8'hF6, 4'd3, 8'd0, 32'b110, 3, hits);
`endif

    send(8'h01, 4'd1, 8'd255);
    cnt = 0; seen = 1'b0;
    for (int i = 0; i < 700 && !seen; i++) begin
      if (i > 0) @(negedge clk);
      if (done) seen = 1'b1;
      else if (dout_valid) cnt++;
    end
    check("t7_done_seen", 32'(seen), 32'd1);
`ifdef SEQ_TX_PARITY_EN
    check("t7_valid_cycles", 32'(cnt), 32'd510);
`else
    check("t7_valid_cycles", 32'(cnt), 32'd255);
`endif
    $display("t7: 255 reps, %0d valid cycles", cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
